// File: rtl/retrodack_brom_arbiter_pkg.sv
// Shared definitions for the two-port boot-ROM arbiter.
package retrodack_brom_arbiter_pkg;

    // Arbiter FSM: waiting for a grant, or waiting on the BROM.
    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    // Number of requesting ports sharing the BROM.
    localparam int unsigned NumPorts = 2;

    // Read data returned with an error response.
    localparam logic [31:0] ErrorData = 32'h0;

    // One-hot ready/error vector for a port index.
    function automatic logic [NumPorts-1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/retrodack_rr_arbiter2.sv
// Two-way arbiter: round-robin pick with a one-bit pointer, or fixed
// priority to port 0. The pointer always moves to the loser of a grant.
module retrodack_rr_arbiter2 #(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_eligible,
    output logic       o_grant_valid,
    output logic       o_grant_idx
);

    logic ptr_q;
    logic ptr_d;

    // Pick a winner among eligible ports and advance the pointer past it.
    always_comb begin
        o_grant_valid = |i_eligible;
        o_grant_idx   = 1'b0;
        ptr_d         = ptr_q;
        if (&i_eligible) begin
            o_grant_idx = (FIXED_PRIORITY != 0) ? 1'b0 : ptr_q;
        end else begin
            o_grant_idx = i_eligible[1];
        end
        if (o_grant_valid) begin
            ptr_d = ~o_grant_idx;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/retrodack_brom_arbiter.sv
// Shares one boot ROM between two requesting ports. In-range accesses issue
// a single-cycle BROM request and return the data three cycles after grant;
// out-of-range accesses and BROM timeouts complete with an error response.
module retrodack_brom_arbiter
    import retrodack_brom_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ROM_BYTES      = 32768,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NumPorts-1:0]      i_request,
    input  logic [32*NumPorts-1:0]   i_address,
    output logic [32*NumPorts-1:0]   o_rdata,
    output logic [NumPorts-1:0]      o_ready,
    output logic [NumPorts-1:0]      o_error,
    output logic                     o_brom_request,
    output logic [31:0]              o_brom_address,
    input  logic [31:0]              i_brom_rdata,
    input  logic                     i_brom_ready
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
    localparam logic [31:0]     RomLimit   = 32'(ROM_BYTES);

    state_e                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      breq_q, breq_d;
    logic [31:0]               baddr_q, baddr_d;
    logic [NumPorts-1:0]       ready_q, ready_d;
    logic [NumPorts-1:0]       error_q, error_d;
    logic [32*NumPorts-1:0]    rdata_q, rdata_d;

    logic [NumPorts-1:0]       eligible;
    logic                      grant_valid;
    logic                      grant_idx;
    logic [31:0]               sel_addr;
    logic [CntW-1:0]           cnt_inc;

    // A port still showing its level request during its own ready cycle is
    // masked so the completed access is not granted a second time.
    always_comb begin
        eligible = '0;
        if (state_q == StIdle) begin
            eligible = i_request & ~ready_q;
        end
    end

    retrodack_rr_arbiter2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_rr_arbiter2 (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_eligible    (eligible),
        .o_grant_valid (grant_valid),
        .o_grant_idx   (grant_idx)
    );

    // Address of the winning port and the incremented wait count.
    always_comb begin
        sel_addr = grant_idx ? i_address[63:32] : i_address[31:0];
        cnt_inc  = cnt_q + CntW'(1);
    end

    // Next-state and registered-output logic of the access FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        breq_d  = 1'b0;
        baddr_d = baddr_q;
        ready_d = '0;
        error_d = '0;
        rdata_d = {NumPorts{ErrorData}};

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    if (sel_addr < RomLimit) begin
                        breq_d  = 1'b1;
                        baddr_d = sel_addr;
                        owner_d = grant_idx;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        // Outside the ROM window: answer immediately with an error.
                        ready_d = port_onehot(grant_idx);
                        error_d = port_onehot(grant_idx);
                    end
                end
            end
            StBusy: begin
                if (i_brom_ready) begin
                    ready_d = port_onehot(owner_q);
                    if (owner_q) begin
                        rdata_d[63:32] = i_brom_rdata;
                    end else begin
                        rdata_d[31:0] = i_brom_rdata;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutVal) begin
                        ready_d = port_onehot(owner_q);
                        error_d = port_onehot(owner_q);
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            breq_q  <= 1'b0;
            baddr_q <= '0;
            ready_q <= '0;
            error_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            breq_q  <= breq_d;
            baddr_q <= baddr_d;
            ready_q <= ready_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
        end
    end

    // Drive ports straight from the registers.
    always_comb begin
        o_ready        = ready_q;
        o_error        = error_q;
        o_rdata        = rdata_q;
        o_brom_request = breq_q;
        o_brom_address = baddr_q;
    end

endmodule
